// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode classes (opcode[6:2]), dmem FSM states
// and the source-register validity helpers used by hazard and forwarding logic.
package pipe_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } pipe_state_e;

    function automatic logic rs1_valid(input logic [4:0] cls);
        return !((cls == OPC_LUI) || (cls == OPC_AUIPC) || (cls == OPC_JAL));
    endfunction

    function automatic logic rs2_valid(input logic [4:0] cls);
        return (cls == OPC_BRANCH) || (cls == OPC_OP) || (cls == OPC_STORE);
    endfunction

    function automatic logic is_mem_op(input logic [4:0] cls);
        return (cls == OPC_LOAD) || (cls == OPC_STORE);
    endfunction

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory access sequencer: issues dmem_req, counts wait cycles and
// latches a sticky fatal timeout when the memory never answers.
module dmem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m_mem_op,
    input  logic        dmem_ready,
    output pipe_state_e state,
    output logic        dmem_req,
    output logic        mem_timeout
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_mem_op && !dmem_ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready) begin
                        state <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= ST_FAULT;
                        mem_timeout <= 1'b1;
                    end
                    if (wait_cnt != CNT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_FAULT;
                    mem_timeout <= 1'b1;
                end
            endcase
        end
    end

    // DONE deliberately drops the request so the held M instruction is not re-issued
    always_comb begin
        dmem_req = ((state == ST_IDLE) && m_mem_op) || (state == ST_WAIT);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline. Optional performance
// counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic [6:0] d_opcode,
    input  logic [4:0] x_rd,
    input  logic [6:0] x_opcode,
    input  logic       x_br_taken,
    input  logic [6:0] m_opcode,
    input  logic       dmem_ready,
    output logic       dmem_req,
    output logic       f_stall,
    output logic       d_stall,
    output logic       x_stall,
    output logic       m_stall,
    output logic       d_flush,
    output logic       x_flush,
    output logic       w_bubble,
    output logic       pc_redirect,
    output logic       mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_mem_stall_cycles,
    output logic [CNT_W-1:0] perf_load_use,
    output logic [CNT_W-1:0] perf_redirects
`endif
);

    logic [4:0]  d_cls, x_cls, m_cls;
    logic        m_mem_op;
    pipe_state_e state;
    logic        mem_stall;
    logic        redirect_cond;
    logic        load_use_cond;
    logic        redirect;
    logic        load_use;
    logic        unused_opc_lsb;

    assign d_cls          = d_opcode[6:2];
    assign x_cls          = x_opcode[6:2];
    assign m_cls          = m_opcode[6:2];
    assign m_mem_op       = is_mem_op(m_cls);
    assign unused_opc_lsb = &{1'b0, d_opcode[1:0], x_opcode[1:0], m_opcode[1:0]};

    dmem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_dmem_wait_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .m_mem_op   (m_mem_op),
        .dmem_ready (dmem_ready),
        .state      (state),
        .dmem_req   (dmem_req),
        .mem_timeout(mem_timeout)
    );

    // Priority: memory stall > control redirect > load-use bubble
    always_comb begin
        mem_stall = ((state == ST_IDLE) && m_mem_op && !dmem_ready)
                  || (state == ST_WAIT) || (state == ST_FAULT);

        redirect_cond = (x_cls == OPC_JAL) || (x_cls == OPC_JALR)
                      || ((x_cls == OPC_BRANCH) && x_br_taken);

        load_use_cond = (x_cls == OPC_LOAD) && (x_rd != 5'd0)
                      && ((rs1_valid(d_cls) && (d_rs1 == x_rd))
                       || (rs2_valid(d_cls) && (d_rs2 == x_rd)));

        redirect = !mem_stall && redirect_cond;
        load_use = !mem_stall && !redirect_cond && load_use_cond;

        f_stall     = mem_stall || load_use;
        d_stall     = mem_stall || load_use;
        x_stall     = mem_stall;
        m_stall     = mem_stall;
        w_bubble    = mem_stall;
        pc_redirect = redirect;
        d_flush     = redirect;
        x_flush     = redirect || load_use;
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_mem_stall_cycles <= '0;
            perf_load_use         <= '0;
            perf_redirects        <= '0;
        end else if (state != ST_FAULT) begin
            if (mem_stall) perf_mem_stall_cycles <= perf_mem_stall_cycles + 1'b1;
            if (load_use)  perf_load_use         <= perf_load_use + 1'b1;
            if (redirect)  perf_redirects        <= perf_redirects + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected output vectors are queued when a
// step is driven and checked against the DUT on the following falling edge.
module tb_pipeline_ctrl;

    localparam logic [6:0] OP_NOP    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // bit order: req f d x m d_flush x_flush w_bubble pc_redirect mem_timeout
    localparam logic [9:0] E_NONE  = 10'b0000000000;
    localparam logic [9:0] E_LU    = 10'b0110001000;
    localparam logic [9:0] E_MEM   = 10'b1111100100;
    localparam logic [9:0] E_RED   = 10'b0000011010;
    localparam logic [9:0] E_REQ   = 10'b1000000000;
    localparam logic [9:0] E_FAULT = 10'b0111100101;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] d_rs1 = '0, d_rs2 = '0, x_rd = '0;
    logic [6:0] d_opcode = OP_NOP, x_opcode = OP_NOP, m_opcode = OP_NOP;
    logic       x_br_taken = 1'b0, dmem_ready = 1'b0;
    logic       dmem_req, f_stall, d_stall, x_stall, m_stall;
    logic       d_flush, x_flush, w_bubble, pc_redirect, mem_timeout;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [9:0]  exp_q[$];
    string       tag_q[$];

    pipeline_ctrl #(
        .MEM_TIMEOUT(8),
        .CNT_W      (32)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_opcode   (d_opcode),
        .x_rd       (x_rd),
        .x_opcode   (x_opcode),
        .x_br_taken (x_br_taken),
        .m_opcode   (m_opcode),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .f_stall    (f_stall),
        .d_stall    (d_stall),
        .x_stall    (x_stall),
        .m_stall    (m_stall),
        .d_flush    (d_flush),
        .x_flush    (x_flush),
        .w_bubble   (w_bubble),
        .pc_redirect(pc_redirect),
        .mem_timeout(mem_timeout)
    );

    always #5 clock = ~clock;

    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] dop,
                        input logic [4:0] xrd, input logic [6:0] xop, input logic br,
                        input logic [6:0] mop, input logic rdy, input logic [9:0] expv);
        logic [9:0] obs;
        logic [9:0] want;
        string      t;
        @(posedge clock);
        #1;
        reset_n    = rst;
        d_rs1      = rs1;
        d_rs2      = rs2;
        d_opcode   = dop;
        x_rd       = xrd;
        x_opcode   = xop;
        x_br_taken = br;
        m_opcode   = mop;
        dmem_ready = rdy;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(negedge clock);
        obs  = {dmem_req, f_stall, d_stall, x_stall, m_stall,
                d_flush, x_flush, w_bubble, pc_redirect, mem_timeout};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
    endtask

    initial begin
        step("reset",        1'b0, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);
        step("load_use_rs1", 1'b1, 5'd5, 5'd6, OP_OP,    5'd5, OP_LOAD,   1'b0, OP_NOP,   1'b0, E_LU);
        step("load_in_m",    1'b1, 5'd5, 5'd6, OP_OP,    5'd0, OP_NOP,    1'b0, OP_LOAD,  1'b1, E_REQ);
        step("load_x0",      1'b1, 5'd0, 5'd0, OP_OP,    5'd0, OP_LOAD,   1'b0, OP_NOP,   1'b0, E_NONE);
        step("load_lui",     1'b1, 5'd5, 5'd5, OP_LUI,   5'd5, OP_LOAD,   1'b0, OP_NOP,   1'b0, E_NONE);
        step("load_use_rs2", 1'b1, 5'd1, 5'd5, OP_STORE, 5'd5, OP_LOAD,   1'b0, OP_NOP,   1'b0, E_LU);
        step("rs2_invalid",  1'b1, 5'd1, 5'd5, OP_NOP,   5'd5, OP_LOAD,   1'b0, OP_NOP,   1'b0, E_NONE);
        step("br_taken",     1'b1, 5'd1, 5'd2, OP_OP,    5'd0, OP_BRANCH, 1'b1, OP_NOP,   1'b0, E_RED);
        step("br_not_taken", 1'b1, 5'd1, 5'd2, OP_OP,    5'd0, OP_BRANCH, 1'b0, OP_NOP,   1'b0, E_NONE);
        step("jalr",         1'b1, 5'd1, 5'd2, OP_OP,    5'd3, OP_JALR,   1'b0, OP_NOP,   1'b0, E_RED);

        step("st_issue",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b0, E_MEM);
        step("st_wait1",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b0, E_MEM);
        step("st_wait2",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b0, E_MEM);
        step("st_ready",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b1, E_MEM);
        step("st_done",      1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b0, E_NONE);
        step("st_idle",      1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);

        step("jal_mem0",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd1, OP_JAL,    1'b0, OP_LOAD,  1'b0, E_MEM);
        step("jal_mem1",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd1, OP_JAL,    1'b0, OP_LOAD,  1'b0, E_MEM);
        step("jal_mem2",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd1, OP_JAL,    1'b0, OP_LOAD,  1'b1, E_MEM);
        step("jal_done",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd1, OP_JAL,    1'b0, OP_LOAD,  1'b0, E_RED);
        step("jal_after",    1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);

        step("to_issue",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_LOAD,  1'b0, E_MEM);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("to_wait%0d", i), 1'b1, 5'd0, 5'd0, OP_NOP, 5'd0, OP_NOP, 1'b0, OP_LOAD, 1'b0, E_MEM);
        end
        step("to_fault",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_LOAD,  1'b0, E_FAULT);
        step("to_sticky",    1'b1, 5'd0, 5'd0, OP_NOP,   5'd1, OP_JAL,    1'b0, OP_NOP,   1'b1, E_FAULT);
        step("to_reset",     1'b0, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);
        step("to_released",  1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);

        step("rw_issue",     1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b0, E_MEM);
        step("rw_wait",      1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_STORE, 1'b0, E_MEM);
        step("rw_reset",     1'b0, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);
        step("rw_released",  1'b1, 5'd0, 5'd0, OP_NOP,   5'd0, OP_NOP,    1'b0, OP_NOP,   1'b0, E_NONE);

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
